// File: rtl/ram_xfer_pkg.sv
// Shared types and constants for the dual-RAM transfer controller.
// Op encodings, FSM states and default geometry live here.
package ram_xfer_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;
    localparam int LAST_ADDR  = 15;

    localparam logic [1:0] OP_CP01 = 2'b00;
    localparam logic [1:0] OP_CP10 = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        CHK,
        DONE
    } state_t;

endpackage

// File: rtl/ram_walk_cnt.sv
// Walk address counter: load-zero, increment, at-last flag.
// Holds at LAST_ADDR so it never wraps inside an operation.
module ram_walk_cnt
    import ram_xfer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_zero,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              at_last
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    assign at_last = (addr == LAST);

    // Walk address register; increment is suppressed at the last address
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr <= '0;
        end else if (load_zero) begin
            addr <= '0;
        end else if (inc && !at_last) begin
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ram_xfer_ctrl.sv
// Copy / swap / compare controller for two registered-read RAMs.
// Compare op is built only when RAM_XFER_COMPARE_EN is defined.
module ram_xfer_ctrl
    import ram_xfer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_we,
    input  logic              host_sel,
    output logic [ADDR_W-1:0] ram0_addr,
    output logic              ram0_mwr,
    output logic [DATA_W-1:0] ram0_mdi,
    input  logic [DATA_W-1:0] ram0_mdo,
    output logic [ADDR_W-1:0] ram1_addr,
    output logic              ram1_mwr,
    output logic [DATA_W-1:0] ram1_mdi,
    input  logic [DATA_W-1:0] ram1_mdo,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [ADDR_W-1:0] mismatch_addr
);

`ifdef RAM_XFER_COMPARE_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] walk;
    logic              walk_last;
    logic              walk_load;
    logic              walk_inc;
    logic              wr0;
    logic              wr1;

    assign walk_load = (state == IDLE) && start;
    assign walk_inc  = (state == WR) || (state == CHK);

    ram_walk_cnt #(
        .ADDR_W (ADDR_W)
    ) u_walk (
        .clk       (clk),
        .resetn    (resetn),
        .load_zero (walk_load),
        .inc       (walk_inc),
        .addr      (walk),
        .at_last   (walk_last)
    );

    // Main FSM with registered busy/done and op latched at start
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            op_q  <= OP_CP01;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q <= op;
                        if (!CMP_EN && op == OP_CMP) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RD;
                            busy  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (CMP_EN && op_q == OP_CMP) begin
                        state <= CHK;
                    end else begin
                        state <= WR;
                    end
                end
`ifdef RAM_XFER_COMPARE_EN
                WR, CHK: begin
`else
                WR: begin
`endif
                    if (walk_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_XFER_COMPARE_EN
    // Sticky first-failure capture during the compare walk
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mismatch      <= 1'b0;
            mismatch_addr <= '0;
        end else if (state == IDLE && start) begin
            mismatch      <= 1'b0;
            mismatch_addr <= '0;
        end else if (state == CHK && !mismatch
                     && ram0_mdo != ram1_mdo) begin
            mismatch      <= 1'b1;
            mismatch_addr <= walk;
        end
    end
`else
    assign mismatch      = 1'b0;
    assign mismatch_addr = '0;
`endif

    // RAM port steering: host pass-through in IDLE, walk otherwise
    always_comb begin
        ram0_addr = walk;
        ram1_addr = walk;
        ram0_mdi  = ram1_mdo;
        ram1_mdi  = ram0_mdo;
        wr0       = 1'b0;
        wr1       = 1'b0;
        if (state == IDLE) begin
            ram0_addr = host_addr;
            ram1_addr = host_addr;
            ram0_mdi  = host_data;
            ram1_mdi  = host_data;
            wr0       = host_we & ~host_sel;
            wr1       = host_we & host_sel;
        end else if (state == WR) begin
            unique case (1'b1)
                (op_q == OP_CP01): wr1 = 1'b1;
                (op_q == OP_CP10): wr0 = 1'b1;
                (op_q == OP_SWAP): begin
                    wr0 = 1'b1;
                    wr1 = 1'b1;
                end
                default: begin
                    wr0 = 1'b0;
                    wr1 = 1'b0;
                end
            endcase
        end
        ram0_mwr = wr0 & resetn;
        ram1_mwr = wr1 & resetn;
    end

endmodule

// File: tb/tb_ram_xfer_ctrl.sv
// Self-checking bench for ram_xfer_ctrl with two behavioural RAMs.
// Honors RAM_XFER_COMPARE_EN for the compare scenario.
module tb_ram_xfer_ctrl;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [1:0] op;
    logic [3:0] host_addr;
    logic [3:0] host_data;
    logic       host_we;
    logic       host_sel;
    logic [3:0] ram0_addr, ram1_addr;
    logic       ram0_mwr, ram1_mwr;
    logic [3:0] ram0_mdi, ram1_mdi;
    logic [3:0] ram0_mdo, ram1_mdo;
    logic       busy, done, mismatch;
    logic [3:0] mismatch_addr;

    logic [3:0] mem0 [16];
    logic [3:0] mem1 [16];

    int total = 0;
    int bad   = 0;

    ram_xfer_ctrl #(
        .ADDR_W (4),
        .DATA_W (4)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .op            (op),
        .host_addr     (host_addr),
        .host_data     (host_data),
        .host_we       (host_we),
        .host_sel      (host_sel),
        .ram0_addr     (ram0_addr),
        .ram0_mwr      (ram0_mwr),
        .ram0_mdi      (ram0_mdi),
        .ram0_mdo      (ram0_mdo),
        .ram1_addr     (ram1_addr),
        .ram1_mwr      (ram1_mwr),
        .ram1_mdi      (ram1_mdi),
        .ram1_mdo      (ram1_mdo),
        .busy          (busy),
        .done          (done),
        .mismatch      (mismatch),
        .mismatch_addr (mismatch_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM models
    always @(posedge clk) begin
        if (ram0_mwr) mem0[ram0_addr] <= ram0_mdi;
        if (ram1_mwr) mem1[ram1_addr] <= ram1_mdi;
        ram0_mdo <= mem0[ram0_addr];
        ram1_mdo <= mem1[ram1_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic host_wr(input logic s, input logic [3:0] a,
                           input logic [3:0] d);
        @(negedge clk);
        host_sel  = s;
        host_addr = a;
        host_data = d;
        host_we   = 1'b1;
        @(negedge clk);
        host_we   = 1'b0;
    endtask

    // Launch op, then sample each cycle until done; op flips mid-run
    task automatic run_op(input logic [1:0] o, output int nbusy,
                          output int done_cyc, output int nmwr);
        @(negedge clk);
        op    = o;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        nbusy    = 0;
        done_cyc = 0;
        nmwr     = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) nbusy++;
            if (ram0_mwr || ram1_mwr) nmwr++;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (c == 3) op = ~o;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [3:0] addr;
        logic [3:0] data;
        logic       we;
        logic       sel;
        logic       e0;
        logic       e1;
    } vec_t;

    vec_t vt [6];

    int nb, dc, nw;

    initial begin
        vt[0] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{4'h3, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{4'h3, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[3] = '{4'hF, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{4'hC, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[5] = '{4'h7, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0};

        resetn    = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        host_addr = 4'h0;
        host_data = 4'h0;
        host_we   = 1'b1;
        host_sel  = 1'b1;

        // Reset state, mwr forced low during reset
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mm", mismatch, 0);
        chk("rst_mma", mismatch_addr, 0);
        chk("rst_mwr1", ram1_mwr, 0);
        host_we = 1'b0;
        resetn  = 1'b1;

        // IDLE host pass-through table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            host_addr = vt[i].addr;
            host_data = vt[i].data;
            host_we   = vt[i].we;
            host_sel  = vt[i].sel;
            #1;
            chk("v_a0", ram0_addr, vt[i].addr);
            chk("v_a1", ram1_addr, vt[i].addr);
            chk("v_d0", ram0_mdi, vt[i].data);
            chk("v_d1", ram1_mdi, vt[i].data);
            chk("v_w0", ram0_mwr, vt[i].e0);
            chk("v_w1", ram1_mwr, vt[i].e1);
        end
        @(negedge clk);
        host_we = 1'b0;

        // Copy ram0 -> ram1
        for (int a = 0; a < 16; a++) host_wr(0, 4'(a), 4'(a));
        for (int a = 0; a < 16; a++) host_wr(1, 4'(a), 4'hF);
        run_op(2'b00, nb, dc, nw);
        chk("cp_busy", nb, 32);
        chk("cp_done", dc, 33);
        chk("cp_nwr", nw, 16);
        chk("cp_bsy_at_done", busy, 0);
        for (int a = 0; a < 16; a++) begin
            chk("cp_ram1", mem1[a], a);
            chk("cp_ram0", mem0[a], a);
        end

        // Swap
        for (int a = 0; a < 16; a++) host_wr(1, 4'(a), 4'(15 - a));
        run_op(2'b10, nb, dc, nw);
        chk("sw_busy", nb, 32);
        chk("sw_done", dc, 33);
        chk("sw_nwr", nw, 16);
        for (int a = 0; a < 16; a++) begin
            chk("sw_ram0", mem0[a], 15 - a);
            chk("sw_ram1", mem1[a], a);
        end

        // Compare
        for (int a = 0; a < 16; a++) host_wr(0, 4'(a), 4'(a));
        for (int a = 0; a < 16; a++) host_wr(1, 4'(a), 4'(a));
        host_wr(1, 4'd6, 4'd0);
        host_wr(1, 4'd9, 4'd0);
        run_op(2'b11, nb, dc, nw);
`ifdef RAM_XFER_COMPARE_EN
        chk("cmp_busy", nb, 32);
        chk("cmp_done", dc, 33);
        chk("cmp_nwr", nw, 0);
        chk("cmp_mm", mismatch, 1);
        chk("cmp_mma", mismatch_addr, 6);
`else
        chk("cmp_busy", nb, 0);
        chk("cmp_done", dc, 1);
        chk("cmp_nwr", nw, 0);
        chk("cmp_mm", mismatch, 0);
        chk("cmp_mma", mismatch_addr, 0);
`endif
        chk("cmp_ram1_6", mem1[6], 0);

        // Host write while busy is dropped, in IDLE it lands
        host_wr(1, 4'd3, 4'd5);
        @(negedge clk);
        op    = 2'b01;
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        host_sel  = 1'b1;
        host_addr = 4'd3;
        host_data = 4'hA;
        host_we   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("hb_busy", busy, 1);
            chk("hb_mwr1", ram1_mwr, 0);
            @(negedge clk);
        end
        host_we = 1'b0;
        nb = 0;
        while (!done && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        chk("hb_done_seen", done, 1);
        chk("hb_ram1_3", mem1[3], 5);
        host_wr(1, 4'd3, 4'hA);
        chk("hi_ram1_3", mem1[3], 4'hA);

        // Start held through DONE is taken in the following IDLE
        @(negedge clk);
        op    = 2'b00;
        start = 1'b1;
        @(negedge clk);
        nb = 0;
        while (!done && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        chk("hold_done_cyc", nb, 32);
        @(negedge clk);
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_done", done, 0);
        @(negedge clk);
        chk("hold_restart", busy, 1);
        start  = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Reset after ten busy cycles of a copy
        for (int a = 0; a < 16; a++) host_wr(0, 4'(a), 4'(a));
        for (int a = 0; a < 16; a++) host_wr(1, 4'(a), 4'hF);
        @(negedge clk);
        op    = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        chk("rm_busy10", busy, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rm_mwr0", ram0_mwr, 0);
        chk("rm_mwr1", ram1_mwr, 0);
        @(negedge clk);
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        host_addr = 4'd9;
        #1;
        chk("rm_idle_addr", ram0_addr, 9);
        resetn = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            if (a < 5) chk("rm_cp", mem1[a], a);
            else       chk("rm_keep", mem1[a], 4'hF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
